// File: rtl/decoder_nx2n_seq_if.sv
// Request/response bundle for the sequenced N-to-2**N decoder.
// master drives the select/control inputs; slave (the decoder) returns z/valid/wrap.
interface decoder_nx2n_seq_if #(
  parameter int unsigned N = 2
) ();
  localparam int unsigned W = 1 << N;

  logic         en;
  logic [1:0]   mode;
  logic [N-1:0] a;
  logic         load;
  logic [W-1:0] z;
  logic         valid;
  logic         wrap;

  modport master (
    output en, mode, a, load,
    input  z, valid, wrap
  );

  modport slave (
    input  en, mode, a, load,
    output z, valid, wrap
  );
endinterface

// File: rtl/decoder_nx2n_seq.sv
// Registered N-to-2**N decoder with decode, thermometer, scan and hold modes.
// A scan counter walks the one-hot output and flags wrap-around; z is optionally active-low.
module decoder_nx2n_seq #(
  parameter int unsigned N          = 2,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  decoder_nx2n_seq_if.slave  bus
);
  localparam int unsigned W = 1 << N;

  typedef enum logic [1:0] {
    ModeDecode = 2'b00,
    ModeTherm  = 2'b01,
    ModeScan   = 2'b10,
    ModeHold   = 2'b11
  } mode_e;

  mode_e        mode;
  logic [W-1:0] z_q, z_d;
  logic         valid_q, valid_d;
  logic         wrap_q, wrap_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] scan_sel;
  logic [W-1:0] onehot_a, onehot_scan, therm;

  assign mode = mode_e'(bus.mode);

  // A load in an enabled scan cycle shows the loaded index right away.
  assign scan_sel = bus.load ? bus.a : cnt_q;

  always_comb begin
    onehot_a              = '0;
    onehot_a[bus.a]       = 1'b1;
    onehot_scan           = '0;
    onehot_scan[scan_sel] = 1'b1;
    therm                 = '0;
    for (int unsigned k = 0; k < W; k++) begin
      therm[k] = (k[N-1:0] <= bus.a);
    end
  end

  always_comb begin
    z_d     = '0;
    valid_d = bus.en;
    wrap_d  = 1'b0;
    cnt_d   = bus.load ? bus.a : cnt_q;
    if (mode == ModeHold) begin
      z_d     = z_q;
      valid_d = valid_q;
    end else if (bus.en) begin
      unique case (mode)
        ModeDecode: z_d = onehot_a;
        ModeTherm:  z_d = therm;
        ModeScan: begin
          z_d    = onehot_scan;
          wrap_d = &scan_sel;
          cnt_d  = scan_sel + N'(1);
        end
        default:    z_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q     <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      z_q     <= z_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.z     = ACTIVE_LOW ? ~z_q : z_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;
endmodule

// File: doc/decoder_nx2n_seq.md
DECODER_NX2N_SEQ -- requirements
Module: decoder_nx2n_seq

Interface
REQ-001 SHALL have parameter N, default 2: select width; output width is 2**N (N in 1..6).
REQ-002 SHALL have parameter ACTIVE_LOW, default 0: 1 inverts every bit of z at the port.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  enable; 0 blanks outputs.
REQ-006 SHALL have port mode  input  2  00 decode, 01 thermometer, 10 scan, 11 hold.
REQ-007 SHALL have port a  input  N  select value; also the scan load value.
REQ-008 SHALL have port load  input  1  loads the scan counter from a.
REQ-009 SHALL have port z  output  2**N  registered decoder output; z[k] corresponds to value k.
REQ-010 SHALL have port valid  output  1  z holds a result of an enabled cycle.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse on scan wrap-around.

Function
REQ-012 SHALL register all outputs: latency one clock from sampled inputs to z, valid, wrap.
REQ-013 Decode mode (00), en=1: SHALL set z to one-hot, with only z[a] set.
REQ-014 Thermometer mode (01), en=1: SHALL set z[k]=1 for all k<=a and 0 otherwise (a=0 gives only z[0]).
REQ-015 Scan mode (10), en=1, load=0: SHALL set z one-hot of cnt and then increment cnt (N bits).
REQ-016 Scan mode: cnt SHALL wrap from 2**N-1 to 0, and wrap SHALL be 1 in the cycle z shows index 2**N-1.
REQ-017 load=1 SHALL set cnt=a next edge regardless of en or mode, and load SHALL take priority over increment.
REQ-018 Scan mode with load=1 and en=1: z SHALL show one-hot of a next cycle; cnt SHALL become a+1 modulo 2**N.
REQ-019 Hold mode (11): z and valid SHALL retain their previous values, cnt SHALL not change unless load=1, and wrap=0.
REQ-020 en=0 (any mode except hold): next cycle z SHALL be all zero (pre-inversion), valid=0, wrap=0, and cnt SHALL be unchanged unless loaded.
REQ-021 valid SHALL be 1 in the cycle after any en=1 cycle in modes 00, 01 or 10.
REQ-022 A mode change SHALL take effect on the next edge, and cnt SHALL be retained across mode changes (scan resumes where it left).
REQ-023 wrap SHALL be 0 in every mode other than scan.
REQ-024 ACTIVE_LOW=1 SHALL invert z only, never valid or wrap.

Reset
REQ-025 rst=1 at an edge SHALL force z=0 (all ones when ACTIVE_LOW=1), valid=0, wrap=0 and cnt=0, overriding load, en and mode.
REQ-026 Reset asserted mid-scan SHALL restart the scan at index 0 on the first enabled scan cycle after release.

Verification
REQ-027 N=2, decode, en=1, a=0,1,2,3 on successive cycles -> z[0],z[1],z[2],z[3] set singly one cycle later, valid=1.
REQ-028 N=2, thermometer, a=2 -> z[0..2]=1, z[3]=0; a=0 -> only z[0]=1.
REQ-029 N=2, scan from reset for 6 cycles -> z walks indices 0,1,2,3,0,1; wrap=1 only alongside index 3.
REQ-030 Scan at index 1 with load=1, a=3 -> next z index 3 with wrap=1, then index 0.
REQ-031 en=0 mid-decode -> z=0 and valid=0 next cycle; hold mode after a=2 decode -> z keeps index 2 for 5 cycles.
REQ-032 ACTIVE_LOW=1, rst mid-scan -> z all ones, valid=0; release, then scan -> z=1110 (index 0 low).
